lsu_stage: RTL

Memory stage directly downstream of the ALU in the RV32I core. Consumes the ALU result as an effective address (loads/stores) or as a pass-through result (all other ops), runs a valid/ready request and response handshake with data memory, forms byte masks and aligned store data, and sign/zero-extends load data. Produces one registered writeback beat per retired instruction and back-pressures execute while a memory access is outstanding.

---
 rtl/lsu_pkg.sv | 73 +++++++
 rtl/lsu_load_align.sv | 28 ++
 rtl/lsu_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store stage: funct3 codes, FSM state
// encodings, byte-mask widths and the access-size helpers used to form
// store lanes and detect misaligned accesses.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_REQ  = 2'd1;
    localparam logic [STATE_W-1:0] S_WAIT = 2'd2;

    localparam int MASK_W = 4;
    localparam logic [MASK_W-1:0] MASK_NONE = 4'b0000;
    localparam logic [MASK_W-1:0] MASK_BYTE = 4'b0001;
    localparam logic [MASK_W-1:0] MASK_HALF = 4'b0011;
    localparam logic [MASK_W-1:0] MASK_WORD = 4'b1111;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    // Loads treat the unsigned variants as byte/half; anything unknown is a word.
    function automatic access_size_e load_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    // Stores only know SB and SH; every other code writes a full word.
    function automatic access_size_e store_size(input logic [2:0] f3);
        case (f3)
            F3_B:    return SZ_BYTE;
            F3_H:    return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input access_size_e sz, input logic [1:0] a);
        case (sz)
            SZ_HALF: return a[0];
            SZ_WORD: return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Half accesses ignore a[0] so the mask always lands on a half boundary.
    function automatic logic [MASK_W-1:0] store_mask(input access_size_e sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: return MASK_BYTE << a;
            SZ_HALF: return MASK_HALF << {a[1], 1'b0};
            default: return MASK_WORD;
        endcase
    endfunction

    // Replicate the low bytes across all lanes so memory can pick any lane.
    function automatic logic [31:0] store_lanes(input access_size_e sz, input logic [31:0] data);
        case (sz)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte or half of the raw memory
// word and sign- or zero-extends it according to funct3. Purely combinational.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  a,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the lane addressed by a, then extend to 32 bits.
    always_comb begin
        byte_sel = rdata[{a, 3'b000} +: 8];
        half_sel = a[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// RV32I memory stage. Passes non-memory results straight to writeback, and
// runs a request/response handshake with data memory for loads and stores,
// holding off execute while an access is outstanding.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses retire immediately with misalign_exc set instead of
// being silently aligned.
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       store_data,
    input  logic [2:0]        funct3,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              ex_we,
    input  logic [4:0]        ex_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    output logic [3:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misalign_exc
);

    logic [STATE_W-1:0] state;
    logic [2:0]         f3_q;
    logic [1:0]         a_q;
    logic [4:0]         rd_q;
    logic               load_q;
    logic               accept;
    logic               mem_op;
    logic               misaligned;
    access_size_e       sz;
    logic [31:0]        load_data;

    assign ex_ready      = (state == S_IDLE) && !rst;
    assign accept        = ex_valid && ex_ready;
    assign mem_op        = is_load || is_store;
    assign mem_req_valid = (state == S_REQ);
    assign sz            = is_load ? load_size(funct3) : store_size(funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = mem_op && is_misaligned(sz, alu_out[1:0]);

    // Exception flag travels with the immediate retire beat of a trapped access.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_exc <= 1'b0;
        end else begin
            misalign_exc <= accept && misaligned;
        end
    end
`else
    assign misaligned   = 1'b0;
    assign misalign_exc = 1'b0;
`endif

    lsu_load_align u_load_align (
        .funct3 (f3_q),
        .a      (a_q),
        .rdata  (mem_resp_rdata),
        .data   (load_data)
    );

    // Main control: accept from execute, sequence the memory handshake, and
    // produce exactly one single-cycle writeback beat per retired instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            f3_q          <= 3'd0;
            a_q           <= 2'd0;
            rd_q          <= 5'd0;
            load_q        <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= 32'd0;
            mem_req_wmask <= MASK_NONE;
            wb_valid      <= 1'b0;
            wb_we         <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= 32'd0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!mem_op) begin
                            wb_valid <= 1'b1;
                            wb_we    <= ex_we && (ex_rd != 5'd0);
                            wb_rd    <= ex_rd;
                            wb_data  <= alu_out;
                        end else if (misaligned) begin
                            wb_valid <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_rd    <= ex_rd;
                            wb_data  <= alu_out;
                        end else begin
                            f3_q          <= funct3;
                            a_q           <= alu_out[1:0];
                            rd_q          <= ex_rd;
                            load_q        <= is_load;
                            mem_req_addr  <= {alu_out[ADDR_W-1:2], 2'b00};
                            mem_req_wdata <= store_lanes(sz, store_data);
                            mem_req_wmask <= is_load ? MASK_NONE : store_mask(sz, alu_out[1:0]);
                            state         <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        if (load_q) begin
                            state <= S_WAIT;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_rd    <= rd_q;
                            wb_data  <= 32'd0;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        wb_valid <= 1'b1;
                        wb_we    <= (rd_q != 5'd0);
                        wb_rd    <= rd_q;
                        wb_data  <= load_data;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
